// File: rtl/mult_booth_if.sv
// -----------------------------------------------------------------------------
// mult_booth_if
// Bundles the control-unit side of the sequential Booth multiplier.
//   MultStart   : start pulse from the control unit (master -> slave)
//   MultA       : 32-bit two's-complement multiplicand (master -> slave)
//   MultB       : 32-bit two's-complement multiplier (master -> slave)
//   MultHighOut : product bits [63:32] (slave -> master)
//   MultLowOut  : product bits [31:0] (slave -> master)
//   MultEnd     : one-cycle result-valid pulse (slave -> master)
//   MultBusy    : operation in progress (slave -> master)
// -----------------------------------------------------------------------------
interface mult_booth_if;
   logic        MultStart;
   logic [31:0] MultA;
   logic [31:0] MultB;
   logic [31:0] MultHighOut;
   logic [31:0] MultLowOut;
   logic        MultEnd;
   logic        MultBusy;

   modport master (
      output MultStart, MultA, MultB,
      input  MultHighOut, MultLowOut, MultEnd, MultBusy
   );

   modport slave (
      input  MultStart, MultA, MultB,
      output MultHighOut, MultLowOut, MultEnd, MultBusy
   );
endinterface

// File: rtl/mult_booth.sv
// -----------------------------------------------------------------------------
// mult_booth
// Sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit signed product.
// One Booth step per clock; a start at edge N yields the result at edge N+32,
// marked by a one-cycle MultEnd pulse, with the FSM back in IDLE at N+33.
//   clock   : the only clock, rising-edge
//   reset   : synchronous active-high reset, priority over MultStart
//   multBus : slave side of mult_booth_if (start/operands in, product/status out)
// -----------------------------------------------------------------------------
module mult_booth (
   input  logic         clock,
   input  logic         reset,
   mult_booth_if.slave  multBus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } stateT;

   stateT       state;
   stateT       nextState;

   logic [31:0] multiplicand;
   logic [32:0] acc;          // 33 bits so a -2^31 multiplicand never overflows
   logic [31:0] qReg;         // multiplier, shifted right one bit per step
   logic        qM1;          // Booth extra bit q-1
   logic [5:0]  stepCount;
   logic [31:0] highReg;
   logic [31:0] lowReg;

   logic [32:0] multiplicandExt;
   logic [32:0] accSum;
   logic [32:0] accNext;
   logic [31:0] qNext;
   logic        lastStep;

   assign multiplicandExt = {multiplicand[31], multiplicand};
   assign lastStep        = (stepCount == 6'd31);

   // Booth add/subtract selected by {q0, q-1}, then arithmetic right shift of
   // {acc, Q, q-1}: acc LSB moves into Q MSB, Q LSB becomes the new q-1.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      accSum = acc;
      unique case ({qReg[0], qM1})
         2'b01:   accSum = acc + multiplicandExt;
         2'b10:   accSum = acc - multiplicandExt;
         default: accSum = acc;
      endcase
   end

   assign accNext = {accSum[32], accSum[32:1]};
   assign qNext   = {accSum[0], qReg[31:1]};

   // State register
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; MultStart only matters in IDLE, so a start seen during
   // RUN or DONE is simply dropped.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (multBus.MultStart) nextState = RUN;
         RUN:     if (lastStep)          nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath: operands are captured only at the accepting edge, so later
   // operand changes cannot disturb a running multiply. The result registers
   // are written only on the 32nd step and otherwise hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         multiplicand <= '0;
         acc          <= '0;
         qReg         <= '0;
         qM1          <= 1'b0;
         stepCount    <= '0;
         highReg      <= '0;
         lowReg       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (multBus.MultStart) begin
                  multiplicand <= multBus.MultA;
                  qReg         <= multBus.MultB;
                  acc          <= '0;
                  qM1          <= 1'b0;
                  stepCount    <= '0;
               end
            end
            RUN: begin
               acc       <= accNext;
               qReg      <= qNext;
               qM1       <= qReg[0];
               stepCount <= stepCount + 6'd1;
               if (lastStep) begin
                  // acc[32] is only a guard bit; the 64-bit product is
                  // the low 32 bits of acc followed by Q.
                  highReg <= accNext[31:0];
                  lowReg  <= qNext;
               end
            end
            default: ;
         endcase
      end
   end

   assign multBus.MultHighOut = highReg;
   assign multBus.MultLowOut  = lowReg;
   assign multBus.MultEnd     = (state == DONE);
   assign multBus.MultBusy    = (state != IDLE);

endmodule

// File: tb/tb_mult_booth.sv
// -----------------------------------------------------------------------------
// tb_mult_booth
// Self-checking bench for mult_booth. Stimulus pushes the expected 64-bit
// product into a queue; a monitor pops and compares whenever MultEnd is seen.
// Timing, busy and hold behaviour are checked alongside the stimulus.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mult_booth;

   logic clock = 1'b0;
   logic reset;

   mult_booth_if bus ();

   mult_booth dut (
      .clock   (clock),
      .reset   (reset),
      .multBus (bus)
   );

   always #5 clock = ~clock;

   int          vectors     = 0;
   int          miscompares = 0;
   int          startCount  = 0;
   int          endCount    = 0;
   logic [63:0] expQ[$];
   logic [63:0] lastResult  = 64'd0;

   task automatic check(input string name, input logic [63:0] actual,
                        input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
      end
   endtask

   // Monitor: every MultEnd must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (bus.MultEnd === 1'b1) begin
         endCount++;
         if (expQ.size() == 0)
            check("spurious MultEnd", {63'd0, bus.MultEnd}, 64'd0);
         else
            check("product", {bus.MultHighOut, bus.MultLowOut}, expQ.pop_front());
      end
   end

   // Runs one multiply starting at the current falling edge (start sampled at
   // edge N). glitchEdge>0 drives garbage operands plus a start pulse sampled at
   // edge N+glitchEdge. keepStart leaves MultStart high on return.
   task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expected, input int glitchEdge,
                        input bit keepStart, input string tag);
      bus.MultStart = 1'b1;
      bus.MultA     = a;
      bus.MultB     = b;
      expQ.push_back(expected);
      startCount++;
      @(negedge clock);                          // after edge N
      if (!keepStart) bus.MultStart = 1'b0;
      check({tag, " busy after start"}, 64'(bus.MultBusy), 64'd1);
      for (int i = 1; i <= 31; i++) begin
         if (i == glitchEdge) begin
            bus.MultStart = 1'b1;
            bus.MultA     = 32'hDEAD_BEEF;
            bus.MultB     = 32'h0BAD_F00D;
         end else if (i == glitchEdge + 1 && !keepStart) begin
            bus.MultStart = 1'b0;
         end
         @(negedge clock);                       // after edge N+i
         check({tag, " result held"}, {bus.MultHighOut, bus.MultLowOut}, lastResult);
         check({tag, " no early end"}, 64'(bus.MultEnd), 64'd0);
      end
      @(negedge clock);                          // after edge N+32
      check({tag, " end at N+32"}, 64'(bus.MultEnd), 64'd1);
      check({tag, " busy in DONE"}, 64'(bus.MultBusy), 64'd1);
      lastResult = expected;
      @(negedge clock);                          // after edge N+33
      check({tag, " end drops"}, 64'(bus.MultEnd), 64'd0);
      check({tag, " busy drops"}, 64'(bus.MultBusy), 64'd0);
      check({tag, " result kept"}, {bus.MultHighOut, bus.MultLowOut}, expected);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
   } vecT;

   vecT directed[$] = '{
      '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F},
      '{32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF},
      '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000},
      '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001},
      '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000},
      '{32'h0000_0000, 32'hFFFF_FFFB, 64'h0000_0000_0000_0000},
      '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 64'h0000_0000_0000_000C},
      '{32'h0000_0005, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD}
   };

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with MultStart asserted: reset must win.
      reset         = 1'b1;
      bus.MultStart = 1'b1;
      bus.MultA     = 32'h0000_0011;
      bus.MultB     = 32'h0000_0022;
      repeat (3) @(negedge clock);
      check("reset hi", 64'(bus.MultHighOut), 64'd0);
      check("reset lo", 64'(bus.MultLowOut), 64'd0);
      check("reset end", 64'(bus.MultEnd), 64'd0);
      check("reset busy", 64'(bus.MultBusy), 64'd0);

      // Start sampled on the first edge after reset release.
      reset = 1'b0;
      foreach (directed[k])
         runOp(directed[k].a, directed[k].b, directed[k].p, 0, 1'b0, "directed");

      // Operand changes and a start pulse mid-RUN are ignored.
      runOp(32'd7, 32'd9, 64'd63, 5, 1'b0, "ignore");

      // Abort by reset at N+10.
      bus.MultStart = 1'b1;
      bus.MultA     = 32'd12345;
      bus.MultB     = 32'd678;
      @(negedge clock);                          // after edge N
      bus.MultStart = 1'b0;
      repeat (9) @(negedge clock);               // after edge N+9
      reset = 1'b1;
      @(negedge clock);                          // after edge N+10
      reset = 1'b0;
      check("abort hi", 64'(bus.MultHighOut), 64'd0);
      check("abort lo", 64'(bus.MultLowOut), 64'd0);
      check("abort busy", 64'(bus.MultBusy), 64'd0);
      lastResult = 64'd0;
      for (int i = 11; i <= 40; i++) begin
         @(negedge clock);
         check("abort no end", 64'(bus.MultEnd), 64'd0);
         check("abort outputs", {bus.MultHighOut, bus.MultLowOut}, 64'd0);
      end
      runOp(32'd2, 32'd3, 64'd6, 0, 1'b0, "after abort");

      // Back-to-back with MultStart held: next start lands on edge N+34.
      runOp(32'd6, 32'd7, 64'd42, 0, 1'b1, "b2b first");
      runOp(32'd10, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFEC, 0, 1'b0, "b2b second");

      // Random signed pairs against a 64-bit reference product.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic [63:0] rp;
         ra = $urandom;
         rb = $urandom;
         rp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
         runOp(ra, rb, rp, 0, 1'b0, "random");
      end

      repeat (3) @(negedge clock);
      check("results outstanding", 64'(expQ.size()), 64'd0);
      check("end count vs starts", 64'(endCount), 64'(startCount));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
